// File: rtl/power_bar_object.sv
// power_bar_object: shot-strength charge/fire/cooldown FSM and bordered power bar drawing object.
module power_bar_object #(
  parameter logic [10:0] TOP_LEFT_X      = 11'd16,
  parameter logic [10:0] TOP_LEFT_Y      = 11'd440,
  parameter int          BAR_H           = 16,
  parameter int          STEP            = 2,
  parameter int          COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        charge,
  input  logic        enable,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        shotValid,
  output logic [7:0]  shotPower
);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [10:0] RIGHT_X  = TOP_LEFT_X + 11'd129;
  localparam logic [10:0] BOTTOM_Y = TOP_LEFT_Y + 11'(BAR_H - 1);
  localparam logic [6:0]  STEP7    = 7'(STEP);
  typedef enum logic [1:0] {IDLE, CHARGING, FIRE, COOLDOWN} state_t;
  state_t        state_q, state_d;
  logic [6:0]    level_q, level_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          draw_d;
  logic [7:0]    rgb_d;
  logic [7:0]    sum;
  logic          in_rect, border, filled;
  logic [10:0]   col;
  logic [7:0]    fill_rgb;
  assign sum = {1'b0, level_q} + 8'(STEP);
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (charge && enable) begin
        state_d = CHARGING;
        level_d = '0;
        dir_d   = 1'b0;
      end
      CHARGING: if (!enable) begin
        state_d = IDLE;
        level_d = '0;
        dir_d   = 1'b0;
      end else if (!charge) begin
        state_d = FIRE;
      end else if (startOfFrame) begin
        // ping-pong: clamp at the ends and reverse direction
        if (!dir_q) begin
          level_d = sum > 8'd127 ? 7'd127 : sum[6:0];
          dir_d   = sum > 8'd127;
        end else begin
          level_d = level_q < STEP7 ? 7'd0 : level_q - STEP7;
          dir_d   = level_q >= STEP7;
        end
      end
      FIRE: begin
        state_d = COOLDOWN;
        cnt_d   = CW'(COOLDOWN_FRAMES);
      end
      COOLDOWN: if (startOfFrame) begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          level_d = '0;
          dir_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_rect  = pixelX >= TOP_LEFT_X && pixelX <= RIGHT_X && pixelY >= TOP_LEFT_Y && pixelY <= BOTTOM_Y;
    border   = pixelX == TOP_LEFT_X || pixelX == RIGHT_X || pixelY == TOP_LEFT_Y || pixelY == BOTTOM_Y;
    col      = pixelX - TOP_LEFT_X - 11'd1;
    filled   = col < {4'b0, level_q};
    fill_rgb = level_q < 7'd64 ? 8'h1C : level_q < 7'd112 ? 8'hFC : 8'hE0;
    draw_d   = in_rect;
    rgb_d    = !in_rect ? 8'h00 : border ? 8'hFF : filled ? fill_rgb : 8'h00;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      level_q        <= '0;
      dir_q          <= 1'b0;
      cnt_q          <= '0;
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
      shotValid      <= 1'b0;
      shotPower      <= 8'h00;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      dir_q          <= dir_d;
      cnt_q          <= cnt_d;
      drawingRequest <= draw_d;
      RGBout         <= rgb_d;
      // shot outputs line up with the cycle the FSM sits in FIRE
      shotValid      <= state_d == FIRE;
      shotPower      <= state_d == FIRE ? {1'b0, level_d} : shotPower;
    end
  end
endmodule
